// File: rtl/guess_arbiter_if.sv
// Groups the two player receiver channels and the game-side guess handshake.
// Latency: none. This file holds wiring only.
// Backpressure: game_rdy stalls the presented guess. Receivers are never stalled.
interface guess_arbiter_if;
    logic       ready_a;
    logic [7:0] rx_byte_a;
    logic       ready_b;
    logic [7:0] rx_byte_b;
    logic       game_rdy;
    logic [7:0] guess;
    logic       guess_valid;
    logic       src;
    logic       pending_a;
    logic       pending_b;
    logic       overflow_a;
    logic       overflow_b;

    // Stimulus side: drives receivers and game_rdy, observes the guess.
    modport master (
        output ready_a, rx_byte_a, ready_b, rx_byte_b, game_rdy,
        input  guess, guess_valid, src, pending_a, pending_b, overflow_a, overflow_b
    );

    // Arbiter side.
    modport slave (
        input  ready_a, rx_byte_a, ready_b, rx_byte_b, game_rdy,
        output guess, guess_valid, src, pending_a, pending_b, overflow_a, overflow_b
    );
endinterface

// File: rtl/guess_arbiter.sv
// Two-player guess arbiter: one-byte slot per player, round-robin onto one valid/ready guess port.
// Latency: guess_valid rises 1 cycle after pending_x. There is a 1-cycle GAP after each accepted guess.
// Backpressure: game_rdy low holds the guess. A new byte arriving at a full slot is dropped and sets sticky overflow_x.
// Option: define GUESS_LETTER_FILTER_EN to fold lowercase letters to uppercase and drop non-letters at capture.
module guess_arbiter (
    input  logic         clk,
    input  logic         nRst,
    guess_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    state_t     state_q, state_d;
    logic       prev_a_q, prev_b_q;
    logic [7:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d;
    logic       pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic       ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    logic       rr_q, rr_d;          // 0 = A has priority when both are pending
    logic [7:0] guess_q, guess_d;
    logic       src_q, src_d;
    logic       valid_q, valid_d;

    logic       rise_a, rise_b;
    logic       acc_a, acc_b;
    logic [7:0] byte_a, byte_b;
    logic       clr_a, clr_b;

    assign rise_a = bus.ready_a & ~prev_a_q;
    assign rise_b = bus.ready_b & ~prev_b_q;

    // Capture-side byte conditioning: optional letter filter and case fold.
    always_comb begin
        acc_a  = 1'b1;
        acc_b  = 1'b1;
        byte_a = bus.rx_byte_a;
        byte_b = bus.rx_byte_b;
`ifdef GUESS_LETTER_FILTER_EN
        if (bus.rx_byte_a >= 8'h61 && bus.rx_byte_a <= 8'h7A)
            byte_a = bus.rx_byte_a - 8'h20;
        else if (!(bus.rx_byte_a >= 8'h41 && bus.rx_byte_a <= 8'h5A))
            acc_a = 1'b0;
        if (bus.rx_byte_b >= 8'h61 && bus.rx_byte_b <= 8'h7A)
            byte_b = bus.rx_byte_b - 8'h20;
        else if (!(bus.rx_byte_b >= 8'h41 && bus.rx_byte_b <= 8'h5A))
            acc_b = 1'b0;
`endif
    end

    // Arbitration FSM: choose a source, hold the offer until accepted, then rest one cycle.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        guess_d = guess_q;
        src_d   = src_q;
        valid_d = valid_q;
        clr_a   = 1'b0;
        clr_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_a_q || pend_b_q) begin
                    // With both pending the pointer decides; otherwise take whichever is full.
                    if (pend_a_q && pend_b_q) src_d = rr_q;
                    else                      src_d = pend_b_q;
                    guess_d = src_d ? slot_b_q : slot_a_q;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.game_rdy) begin
                    clr_a   = ~src_q;
                    clr_b   = src_q;
                    valid_d = 1'b0;
                    rr_d    = ~src_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Slot bookkeeping: capture on a rising strobe, drop on full, and let capture win over clear.
    always_comb begin
        slot_a_d = slot_a_q;
        slot_b_d = slot_b_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        ovf_a_d  = ovf_a_q;
        ovf_b_d  = ovf_b_q;
        if (rise_a && acc_a) begin
            if (pend_a_q && !clr_a) begin
                ovf_a_d = 1'b1;
            end else begin
                slot_a_d = byte_a;
                pend_a_d = 1'b1;
            end
        end else if (clr_a) begin
            pend_a_d = 1'b0;
        end
        if (rise_b && acc_b) begin
            if (pend_b_q && !clr_b) begin
                ovf_b_d = 1'b1;
            end else begin
                slot_b_d = byte_b;
                pend_b_d = 1'b1;
            end
        end else if (clr_b) begin
            pend_b_d = 1'b0;
        end
    end

    // State registers. The previous strobe samples reset high, so a strobe held across reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q  <= IDLE;
            prev_a_q <= 1'b1;
            prev_b_q <= 1'b1;
            slot_a_q <= 8'h00;
            slot_b_q <= 8'h00;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            ovf_a_q  <= 1'b0;
            ovf_b_q  <= 1'b0;
            rr_q     <= 1'b0;
            guess_q  <= 8'h00;
            src_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_a_q <= bus.ready_a;
            prev_b_q <= bus.ready_b;
            slot_a_q <= slot_a_d;
            slot_b_q <= slot_b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            ovf_a_q  <= ovf_a_d;
            ovf_b_q  <= ovf_b_d;
            rr_q     <= rr_d;
            guess_q  <= guess_d;
            src_q    <= src_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.guess       = guess_q;
    assign bus.guess_valid = valid_q;
    assign bus.src         = src_q;
    assign bus.pending_a   = pend_a_q;
    assign bus.pending_b   = pend_b_q;
    assign bus.overflow_a  = ovf_a_q;
    assign bus.overflow_b  = ovf_b_q;
endmodule

// File: tb/tb_guess_arbiter.sv
// Bench for guess_arbiter: directed scenarios, then random traffic, against a transaction-level player/slot model.
// Inputs change on the falling edge. Accepted guesses are scoreboarded separately from the per-cycle flag checks.
// Build with GUESS_LETTER_FILTER_EN defined to exercise the letter-filter variant.
module tb_guess_arbiter;
    logic clk;
    logic nRst;
    guess_arbiter_if bus ();

    guess_arbiter dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int delivered = 0;
    bit primed = 0;

    // Reference model: each player owns a one-byte mailbox. The game sees at most one offer at a time.
    logic       m_prev [2];
    logic       m_full [2];
    logic [7:0] m_val  [2];
    logic       m_ovf  [2];
    logic       m_turn;        // player favoured when both mailboxes hold bytes
    logic       m_offer;
    logic       m_rest;        // game just took a guess and gets one quiet cycle
    logic [7:0] m_guess;
    logic       m_src;
    logic [8:0] exp_q [$];     // {src, guess} of each guess the game should accept

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] cond_byte(input logic [7:0] b);
`ifdef GUESS_LETTER_FILTER_EN
        if (b >= 8'h61 && b <= 8'h7A) return {1'b1, b - 8'h20};
        if (b >= 8'h41 && b <= 8'h5A) return {1'b1, b};
        return {1'b0, b};
`else
        return {1'b1, b};
`endif
    endfunction

    task automatic model_step(input logic ra, input logic [7:0] ba, input logic rb,
                              input logic [7:0] bb, input logic g, input logic rst_n);
        logic       r    [2];
        logic [7:0] b    [2];
        logic       took;
        logic       taker;
        logic       pick;
        logic [8:0] f;
        if (!rst_n) begin
            for (int x = 0; x < 2; x++) begin
                m_prev[x] = 1'b1; m_full[x] = 1'b0; m_val[x] = 8'h00; m_ovf[x] = 1'b0;
            end
            m_turn = 1'b0; m_offer = 1'b0; m_rest = 1'b0; m_guess = 8'h00; m_src = 1'b0;
            return;
        end
        r[0] = ra; r[1] = rb; b[0] = ba; b[1] = bb;
        took  = m_offer && g;
        taker = m_src;
        // The game side reacts to the mailboxes as they stood before this edge.
        if (m_offer) begin
            if (g) begin
                exp_q.push_back({m_src, m_guess});
                m_offer = 1'b0;
                m_rest  = 1'b1;
                m_turn  = ~m_src;
            end
        end else if (m_rest) begin
            m_rest = 1'b0;
        end else if (m_full[0] || m_full[1]) begin
            pick    = (m_full[0] && m_full[1]) ? m_turn : m_full[1];
            m_offer = 1'b1;
            m_src   = pick;
            m_guess = m_val[pick];
        end
        for (int x = 0; x < 2; x++) begin
            f = cond_byte(b[x]);
            if (r[x] && !m_prev[x] && f[8]) begin
                if (m_full[x] && !(took && taker == x[0])) m_ovf[x] = 1'b1;
                else begin m_val[x] = f[7:0]; m_full[x] = 1'b1; end
            end else if (took && taker == x[0]) begin
                m_full[x] = 1'b0;
            end
            m_prev[x] = r[x];
        end
    endtask

    // One cycle: check outputs against the model, then apply new inputs and advance the model.
    task automatic cyc(input logic ra, input logic [7:0] ba, input logic rb,
                       input logic [7:0] bb, input logic g, input logic rst_n);
        @(negedge clk);
        if (primed) begin
            chk("guess_valid", {8'h00, bus.guess_valid}, {8'h00, m_offer});
            chk("guess",       {1'b0, bus.guess},        {1'b0, m_guess});
            chk("src",         {8'h00, bus.src},         {8'h00, m_src});
            chk("pending_a",   {8'h00, bus.pending_a},   {8'h00, m_full[0]});
            chk("pending_b",   {8'h00, bus.pending_b},   {8'h00, m_full[1]});
            chk("overflow_a",  {8'h00, bus.overflow_a},  {8'h00, m_ovf[0]});
            chk("overflow_b",  {8'h00, bus.overflow_b},  {8'h00, m_ovf[1]});
        end
        bus.ready_a   = ra;
        bus.rx_byte_a = ba;
        bus.ready_b   = rb;
        bus.rx_byte_b = bb;
        bus.game_rdy  = g;
        nRst          = rst_n;
        model_step(ra, ba, rb, bb, g, rst_n);
        primed = 1;
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, g, 1'b1);
    endtask

    // Monitor: every guess the game accepts must be the next one the model expects.
    always begin
        @(negedge clk);
        #2;
        if (nRst === 1'b1 && bus.guess_valid === 1'b1 && bus.game_rdy === 1'b1) begin
            delivered++;
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", {bus.src, bus.guess}, 9'h1FF);
            end else begin
                chk("delivered_guess", {bus.src, bus.guess}, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.ready_a = 1'b1; bus.rx_byte_a = 8'h00;
        bus.ready_b = 1'b0; bus.rx_byte_b = 8'h00;
        bus.game_rdy = 1'b0; nRst = 1'b0;

        // Reset with ready_a held high through release: no capture.
        repeat (3) cyc(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Single byte from A, held until the game accepts it.
        cyc(1'b1, 8'h45, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(4, 1'b0);
        idle(1, 1'b1);
        idle(3, 1'b0);

        // Both players at once, twice. Then A alone, then both again, so B goes first.
        cyc(1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 1'b1);
        idle(10, 1'b1);
        cyc(1'b1, 8'h41, 1'b1, 8'h42, 1'b0, 1'b1);
        idle(10, 1'b1);
        cyc(1'b1, 8'h4B, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(6, 1'b1);
        cyc(1'b1, 8'h4C, 1'b1, 8'h4D, 1'b0, 1'b1);
        idle(10, 1'b1);

        // Overflow on A: the second byte is dropped and the flag sticks.
        cyc(1'b1, 8'h43, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(1, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Lowercase and non-letter bytes from B.
        cyc(1'b0, 8'h00, 1'b1, 8'h7A, 1'b1, 1'b1);
        idle(6, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 1'b1);
        idle(6, 1'b1);

        // Reset while a guess is offered and both slots are full.
        cyc(1'b1, 8'h50, 1'b1, 8'h51, 1'b0, 1'b1);
        idle(3, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] ba, bb;
            ba = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h41, 8'h7A)) : 8'($urandom_range(0, 255));
            bb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h41, 8'h7A)) : 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 2) == 0, ba, $urandom_range(0, 2) == 0, bb,
                $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
        end
        idle(10, 1'b1);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 9'(exp_q.size()), 9'd0);
        if (delivered == 0) chk("any_delivery", 9'd0, 9'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/guess_arbiter.md
GUESS_ARBITER -- requirements
Module: guess_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: nRst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have port: ready_a  input  1  player A receiver byte-ready strobe.
REQ-004 SHALL have port: rx_byte_a  input  8  player A received byte; valid when ready_a rises.
REQ-005 SHALL have port: ready_b  input  1  player B receiver byte-ready strobe.
REQ-006 SHALL have port: rx_byte_b  input  8  player B received byte; valid when ready_b rises.
REQ-007 SHALL have port: game_rdy  input  1  game logic accepts the presented guess.
REQ-008 SHALL have port: guess  output  8  guess byte presented to game logic.
REQ-009 SHALL have port: guess_valid  output  1  guess stable and offered.
REQ-010 SHALL have port: src  output  1  owner of presented guess (0=A, 1=B).
REQ-011 SHALL have ports: pending_a, pending_b  output  1 each  per-source slot holds an undelivered byte.
REQ-012 SHALL have ports: overflow_a, overflow_b  output  1 each  sticky byte-dropped flag per source.

Function
REQ-013 SHALL capture rx_byte_x into slot x only on a rising edge of ready_x (sampled high at a posedge, low at the previous posedge); a held-high level SHALL NOT recapture.
REQ-014 SHALL set pending_x in the register update at the posedge where the rising edge is sampled.
REQ-015 SHALL, when a rising edge arrives while slot x is full and not being cleared that cycle, discard the new byte, keep the old one, and set overflow_x until reset.
REQ-016 SHALL, when capture and transfer-clear of the same slot coincide, keep the new byte with pending_x = 1.
REQ-017 SHALL implement FSM states IDLE, PRESENT, GAP; reset state IDLE.
REQ-018 SHALL, in IDLE with any slot pending, select a source, load guess/src from it, assert guess_valid, and enter PRESENT at the next posedge (1 cycle after pending_x rises).
REQ-019 SHALL select by round-robin pointer when both slots are pending; with one pending, select it regardless of pointer.
REQ-020 SHALL hold guess, src, guess_valid constant in PRESENT until game_rdy is sampled high.
REQ-021 SHALL, on game_rdy sampled high in PRESENT, clear the selected slot, deassert guess_valid, point round-robin at the other source, and enter GAP.
REQ-022 SHALL leave GAP for IDLE after exactly one cycle, guaranteeing guess_valid low for at least one cycle between guesses.
REQ-023 SHALL ignore game_rdy in IDLE and GAP.
REQ-024 SHALL keep guess at its last value when guess_valid is low.

Reset
REQ-025 SHALL, with nRst low at a posedge, set guess=8'h00, guess_valid=0, src=0, pending_a/b=0, overflow_a/b=0, round-robin pointer=A, state=IDLE.
REQ-026 SHALL reset the stored previous ready_a/ready_b samples to 1, so a ready held high across reset release is not captured.
REQ-027 SHALL, on reset mid-transfer, discard both slots and any presented guess without completing the handshake.

Configuration
REQ-028 SHALL, with macro GUESS_LETTER_FILTER_EN defined, fold bytes 8'h61-8'h7A to uppercase (subtract 8'h20) at capture and discard bytes outside 8'h41-8'h5A / 8'h61-8'h7A (no pending, no overflow).
REQ-029 SHALL, without GUESS_LETTER_FILTER_EN, capture every byte unmodified.

Verification
REQ-030 SHALL cover: reset with ready_a held high, release -> no capture, pending_a=0, guess=8'h00, guess_valid=0.
REQ-031 SHALL cover: ready_a rise with rx_byte_a=8'h45, game_rdy=0 -> pending_a next cycle, guess=8'h45, src=0, guess_valid one cycle later, held; game_rdy=1 -> guess_valid low next cycle, pending_a=0, one-cycle GAP.
REQ-032 SHALL cover: both sources pending (A=8'h41, B=8'h42) from reset -> A delivered first, then B; repeat with both pending -> A delivered again only after B (alternation).
REQ-033 SHALL cover: A pending 8'h43, second ready_a rise with 8'h44 before delivery -> overflow_a=1, delivered guess 8'h43, overflow_a remains 1.
REQ-034 SHALL cover: with GUESS_LETTER_FILTER_EN, rx_byte_b=8'h7A -> guess=8'h5A; rx_byte_b=8'h31 -> pending_b stays 0; without macro, 8'h31 delivered unchanged.
REQ-035 SHALL cover: nRst asserted during PRESENT with both slots pending -> all outputs at reset values next posedge, no guess delivered after release.
